calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Control FSM for the GoBoard operand/ALU/display datapath.
- Takes debounced switch levels and sequences entry of operand A, then operand B, then compute, then result display. Supports op select and result chaining.
- Sits between the Debounce_Switch instances and Binary_To_7Segment in the top level.
- LED/segment inversion stays in the top level; all outputs here are active-high.

Parameters:
- WIDTH, 8: operand/counter/result width.
- REPEAT_DELAY, 12500000: cycles i_Inc must stay high after its press edge before the first auto-repeat (0.5 s at 25 MHz).
- REPEAT_RATE, 2500000: cycles between subsequent auto-repeats.

Ports:
- i_Clk  in  1  system clock, 25 MHz.
- i_Rst_n  in  1  reset.
- i_Inc  in  1  debounced level: increment entry counter.
- i_Next  in  1  debounced level: commit/advance.
- i_Op  in  1  debounced level: cycle operation.
- i_Clr  in  1  debounced level: clear to start.
- o_Disp  out  WIDTH  value to display.
- o_A  out  WIDTH  operand A register.
- o_B  out  WIDTH  operand B register.
- o_Op  out  2  00 ADD, 01 SUB, 10 AND, 11 XOR.
- o_State  out  2  00 ENTER_A, 01 ENTER_B, 10 COMPUTE, 11 RESULT.
- o_Carry  out  1  ADD carry-out / SUB borrow.
- o_Result_Valid  out  1  result on o_Disp is current.
- o_LED_A  out  1  A committed.
- o_LED_B  out  1  B committed.

Behaviour:
- Clocking and reset: one clock, i_Clk. Reset i_Rst_n is asynchronous, active-low.
- Reset values:
  - state ENTER_A; count, A, B, result all 0; op 00; o_Carry 0; o_Result_Valid 0; LEDs 0; o_Disp 0.
  - Edge-detect history registers reset to 1, so a button held through reset produces no press until it is released and pressed again.
- Press detection: a press is a rising edge where the input is sampled 1 and its history register holds 0. It acts at that same edge: zero added latency beyond the sampling edge.
- Same-edge priority: Clr > Next > Op > Inc. Lower-priority presses on that edge are dropped, and so is any auto-repeat tick.
- Clr press, any state: go to ENTER_A; clear count, A, B, result, carry, valid and both LEDs. op is retained.
- Entry counter:
  - WIDTH bits, wraps 2^WIDTH-1 -> 0.
  - Changes only in ENTER_A/ENTER_B; Inc presses and repeat ticks are ignored in COMPUTE/RESULT.
- Auto-repeat:
  - A hold counter starts at the Inc press edge and resets whenever i_Inc is sampled 0.
  - With i_Inc continuously high, extra increments occur REPEAT_DELAY cycles after the press edge, then every REPEAT_RATE cycles thereafter.
  - Hold counter width is clog2(REPEAT_DELAY+1) and it saturates (no wrap).
- ENTER_A:
  - o_Disp = count.
  - Next: A <= count, o_LED_A <= 1, count <= 0, go to ENTER_B.
  - Op: cycle op 00->01->10->11->00; no state change.
- ENTER_B:
  - o_Disp = count.
  - Next: B <= count, o_LED_B <= 1, count <= 0, go to COMPUTE.
  - Op: cycle op as in ENTER_A.
- COMPUTE: exactly one cycle, no input acted on except Clr.
  - ADD: {carry, result} = A + B.
  - SUB: result = A - B mod 2^WIDTH, carry = (A < B).
  - AND / XOR: carry = 0.
  - Registered at exit; go to RESULT with o_Result_Valid <= 1.
  - o_Disp holds its previous value during COMPUTE.
- RESULT:
  - o_Disp = result.
  - Op: cycle op, o_Result_Valid <= 0, go to COMPUTE (recompute with same A/B).
  - Next (chaining): A <= result, B <= 0, o_LED_B <= 0, o_LED_A stays 1, count <= 0, o_Result_Valid <= 0, go to ENTER_B.
- o_Disp is a combinational mux of registered state only. All other outputs are direct register outputs.
- Reset asserted mid-operation (any state, including COMPUTE) returns all outputs to reset values immediately, without waiting for a clock edge.

Test Plan:
(Parameters for all scenarios: WIDTH=8, REPEAT_DELAY=8, REPEAT_RATE=4.)
1. Reset; 5 Inc presses; Next; 3 Inc presses; Next -> o_State 10 for one cycle, then 11; o_A=0x05, o_B=0x03, o_Disp=0x08, o_Carry=0, o_Result_Valid=1, both LEDs 1.
2. A=0xF0, B=0x20, ADD -> o_Disp=0x10, o_Carry=1. Then successive Op presses -> SUB 0xD0/carry 0, AND 0x20, XOR 0xD0, ADD 0x10. Each result appears 2 edges after its press, with o_Result_Valid low during COMPUTE.
3. A=0x03, B=0x05, SUB -> o_Disp=0xFE, o_Carry=1. Counter at 0xFF plus one Inc press -> 0x00.
4. Press Inc at edge 0 and hold high through edge 20 -> count increments at edges 0, 8, 12, 16, 20: total 5. Release for one cycle and press again -> exactly one immediate increment.
5. In ENTER_B with count=0x07, Clr and Next pressed on the same edge -> ENTER_A, B=0, both LEDs 0, op unchanged. Reset asserted mid-COMPUTE -> all outputs at reset values before the next clock edge.
6. In RESULT showing 0x08, Next -> ENTER_B, o_A=0x08, o_LED_B=0; 2 Inc presses, Next -> RESULT, o_Disp=0x0A.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer: operand entry, ALU sequencing and result display control for the GoBoard calculator
module calc_sequencer #(
  parameter int WIDTH = 8,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE = 2500000
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Inc,
  input  logic             i_Next,
  input  logic             i_Op,
  input  logic             i_Clr,
  output logic [WIDTH-1:0] o_Disp,
  output logic [WIDTH-1:0] o_A,
  output logic [WIDTH-1:0] o_B,
  output logic [1:0]       o_Op,
  output logic [1:0]       o_State,
  output logic             o_Carry,
  output logic             o_Result_Valid,
  output logic             o_LED_A,
  output logic             o_LED_B
);
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  typedef enum logic [1:0] {ENTER_A, ENTER_B, COMPUTE, RESULT} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] count, count_d, a_d, b_d, result, result_d;
  logic [WIDTH:0] alu;
  logic [1:0] op_d;
  logic [3:0] hist;
  logic [HW-1:0] hold, hold_d;
  logic carry_d, valid_d, led_a_d, led_b_d, from_res, from_res_d;
  logic clr_p, next_p, op_p, inc_p, tick;
  assign clr_p = i_Clr & ~hist[3];
  assign next_p = i_Next & ~hist[2];
  assign op_p = i_Op & ~hist[1];
  assign inc_p = i_Inc & ~hist[0];
  assign tick = i_Inc & (hold == HW'(REPEAT_DELAY));
  assign hold_d = !i_Inc ? '0 : inc_p ? HW'(1) : tick ? HW'(REPEAT_DELAY - REPEAT_RATE + 1) : hold == '0 ? '0 : hold + HW'(1);
  assign alu = o_Op == 2'd0 ? {1'b0, o_A} + {1'b0, o_B} : o_Op == 2'd1 ? {1'b0, o_A} - {1'b0, o_B} : {1'b0, o_Op[0] ? o_A ^ o_B : o_A & o_B};
  assign o_Disp = state == RESULT ? result : state == COMPUTE ? (from_res ? result : o_B) : count;
  assign o_State = state;
  always_comb begin
    state_d = state;
    count_d = count;
    a_d = o_A;
    b_d = o_B;
    result_d = result;
    op_d = o_Op;
    carry_d = o_Carry;
    valid_d = o_Result_Valid;
    led_a_d = o_LED_A;
    led_b_d = o_LED_B;
    from_res_d = from_res;
    if (clr_p) begin
      state_d = ENTER_A;
      count_d = '0;
      a_d = '0;
      b_d = '0;
      result_d = '0;
      carry_d = 1'b0;
      valid_d = 1'b0;
      led_a_d = 1'b0;
      led_b_d = 1'b0;
    end else if (state == COMPUTE) begin
      result_d = alu[WIDTH-1:0];
      carry_d = alu[WIDTH];
      valid_d = 1'b1;
      state_d = RESULT;
    end else if (next_p) begin
      count_d = '0;
      state_d = state == ENTER_B ? COMPUTE : ENTER_B;
      from_res_d = 1'b0;
      if (state == ENTER_A) begin
        a_d = count;
        led_a_d = 1'b1;
      end else if (state == ENTER_B) begin
        b_d = count;
        led_b_d = 1'b1;
      end else begin
        a_d = result;
        b_d = '0;
        led_b_d = 1'b0;
        valid_d = 1'b0;
      end
    end else if (op_p) begin
      op_d = o_Op + 2'd1;
      if (state == RESULT) begin
        state_d = COMPUTE;
        valid_d = 1'b0;
        from_res_d = 1'b1;
      end
    end else if ((inc_p | tick) && !state[1]) begin
      count_d = count + WIDTH'(1);
    end
  end
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= ENTER_A;
      count <= '0;
      o_A <= '0;
      o_B <= '0;
      result <= '0;
      o_Op <= 2'd0;
      o_Carry <= 1'b0;
      o_Result_Valid <= 1'b0;
      o_LED_A <= 1'b0;
      o_LED_B <= 1'b0;
      from_res <= 1'b0;
      hist <= '1;
      hold <= '0;
    end else begin
      state <= state_d;
      count <= count_d;
      o_A <= a_d;
      o_B <= b_d;
      result <= result_d;
      o_Op <= op_d;
      o_Carry <= carry_d;
      o_Result_Valid <= valid_d;
      o_LED_A <= led_a_d;
      o_LED_B <= led_b_d;
      from_res <= from_res_d;
      hist <= {i_Clr, i_Next, i_Op, i_Inc};
      hold <= hold_d;
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench for calc_sequencer
module tb_calc_sequencer;
  logic i_Clk = 0, i_Rst_n = 1, i_Inc = 0, i_Next = 0, i_Op = 0, i_Clr = 0;
  logic [7:0] o_Disp, o_A, o_B;
  logic [1:0] o_Op, o_State;
  logic o_Carry, o_Result_Valid, o_LED_A, o_LED_B;
  typedef struct packed {logic [7:0] disp; logic carry; logic [7:0] a; logic [7:0] b;} exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, fails = 0;
  logic prev_valid = 0;
  always #5 i_Clk = ~i_Clk;
  calc_sequencer #(.WIDTH(8), .REPEAT_DELAY(8), .REPEAT_RATE(4)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Inc(i_Inc), .i_Next(i_Next), .i_Op(i_Op), .i_Clr(i_Clr),
    .o_Disp(o_Disp), .o_A(o_A), .o_B(o_B), .o_Op(o_Op), .o_State(o_State), .o_Carry(o_Carry),
    .o_Result_Valid(o_Result_Valid), .o_LED_A(o_LED_A), .o_LED_B(o_LED_B)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic chk_reset(input string name);
    chk(name, {o_Disp, o_A, o_B, o_Op, o_State, o_Carry, o_Result_Valid, o_LED_A, o_LED_B}, 32'h0);
  endtask
  task automatic press(input int k);
    @(negedge i_Clk);
    {i_Clr, i_Op, i_Next, i_Inc} = 4'b1 << k;
    @(negedge i_Clk);
    {i_Clr, i_Op, i_Next, i_Inc} = 4'b0;
  endtask
  task automatic enter(input int n);
    repeat (n) press(0);
  endtask
  task automatic expect_res(input logic [7:0] d, input logic c, input logic [7:0] a, input logic [7:0] b);
    sb.push_back({d, c, a, b});
  endtask
  always @(negedge i_Clk) begin
    if (o_Result_Valid === 1'b1 && !prev_valid) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_result: got disp 0x%0h, expected no result", o_Disp);
      end else begin
        e = sb.pop_front();
        chk("res_disp", o_Disp, e.disp);
        chk("res_carry", o_Carry, e.carry);
        chk("res_a", o_A, e.a);
        chk("res_b", o_B, e.b);
      end
    end
    prev_valid <= o_Result_Valid === 1'b1;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    logic [7:0] res_t [4];
    logic carry_t [4];
    logic [7:0] prev_disp;
    res_t = '{8'hD0, 8'h20, 8'hD0, 8'h10};
    carry_t = '{1'b0, 1'b0, 1'b0, 1'b1};
    #2 i_Rst_n = 0;
    #1 chk_reset("reset_state");
    repeat (2) @(negedge i_Clk);
    i_Rst_n = 1;
    enter(5);
    chk("count_a", o_Disp, 8'h05);
    press(1);
    chk("a_commit", {o_State, o_A, o_LED_A, o_Disp}, {2'd1, 8'h05, 1'b1, 8'h00});
    enter(3);
    expect_res(8'h08, 1'b0, 8'h05, 8'h03);
    press(1);
    chk("compute_state", {o_State, o_Result_Valid, o_Disp}, {2'd2, 1'b0, 8'h03});
    @(negedge i_Clk);
    chk("result_state", {o_State, o_LED_A, o_LED_B}, {2'd3, 1'b1, 1'b1});
    press(1);
    chk("chain", {o_State, o_A, o_B, o_LED_A, o_LED_B, o_Result_Valid}, {2'd1, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0});
    enter(2);
    expect_res(8'h0A, 1'b0, 8'h08, 8'h02);
    press(1);
    @(negedge i_Clk);
    chk("chain_result", o_State, 2'd3);
    press(3);
    chk("clr", {o_State, o_A, o_LED_A, o_LED_B, o_Result_Valid, o_Disp}, {2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00});
    enter(8'hF0);
    press(1);
    enter(8'h20);
    expect_res(8'h10, 1'b1, 8'hF0, 8'h20);
    press(1);
    @(negedge i_Clk);
    prev_disp = 8'h10;
    for (int i = 0; i < 4; i++) begin
      expect_res(res_t[i], carry_t[i], 8'hF0, 8'h20);
      press(2);
      chk("op_compute", {o_State, o_Result_Valid, o_Disp}, {2'd2, 1'b0, prev_disp});
      @(negedge i_Clk);
      chk("op_result", {o_State, o_Op}, {2'd3, 2'((i + 1) % 4)});
      prev_disp = res_t[i];
    end
    press(3);
    press(2);
    chk("op_in_enter_a", {o_State, o_Op}, {2'd0, 2'd1});
    enter(3);
    press(1);
    enter(5);
    expect_res(8'hFE, 1'b1, 8'h03, 8'h05);
    press(1);
    @(negedge i_Clk);
    press(3);
    enter(255);
    chk("count_max", o_Disp, 8'hFF);
    press(0);
    chk("count_wrap", o_Disp, 8'h00);
    @(negedge i_Clk);
    i_Inc = 1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge i_Clk);
      chk("repeat", o_Disp, 8'(1 + (k >= 8 ? 1 + (k - 8) / 4 : 0)));
    end
    i_Inc = 0;
    @(negedge i_Clk);
    i_Inc = 1;
    @(negedge i_Clk);
    chk("repress", o_Disp, 8'h06);
    repeat (3) @(negedge i_Clk);
    i_Inc = 0;
    chk("repress_hold", o_Disp, 8'h06);
    press(3);
    enter(1);
    press(1);
    enter(7);
    @(negedge i_Clk);
    i_Clr = 1;
    i_Next = 1;
    @(negedge i_Clk);
    i_Clr = 0;
    i_Next = 0;
    chk("clr_over_next", {o_State, o_A, o_B, o_LED_A, o_LED_B, o_Op, o_Disp}, {2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd1, 8'h00});
    enter(1);
    press(1);
    enter(1);
    press(1);
    chk("pre_reset_compute", o_State, 2'd2);
    #1 i_Rst_n = 0;
    #1 chk_reset("async_reset");
    i_Inc = 1;
    @(negedge i_Clk);
    i_Rst_n = 1;
    repeat (2) @(negedge i_Clk);
    chk("held_through_reset", o_Disp, 8'h00);
    i_Inc = 0;
    press(0);
    chk("after_held_release", o_Disp, 8'h01);
    repeat (2) @(negedge i_Clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
